// File: rtl/alu_cmd_pkg.sv
// Shared opcode, ALU select and command types for alu_op_sequencer.
// FWD_A_EN adds the per-command forward-operand flag to alu_cmd_t.
package alu_cmd_pkg;

    typedef enum logic [2:0] {
        OP_MUL     = 3'd0,
        OP_ADD     = 3'd1,
        OP_SUB     = 3'd2,
        OP_AND     = 3'd3,
        OP_OR      = 3'd4,
        OP_XOR     = 3'd5,
        OP_SMUL    = 3'd6,
        OP_ILLEGAL = 3'd7
    } alu_op_e;

    localparam logic [4:0] SEL_MUL  = 5'b00000;
    localparam logic [4:0] SEL_ADD  = 5'b00001;
    localparam logic [4:0] SEL_SUB  = 5'b00010;
    localparam logic [4:0] SEL_AND  = 5'b00100;
    localparam logic [4:0] SEL_OR   = 5'b01000;
    localparam logic [4:0] SEL_XOR  = 5'b10000;
    localparam logic [4:0] SEL_SMUL = 5'b11111;

    localparam int FLAG_ZERO     = 0;
    localparam int FLAG_NEGATIVE = 1;
    localparam int FLAG_OVERFLOW = 2;
    localparam int FLAG_CARRY    = 3;

    typedef struct packed {
        alu_op_e    op;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       bin;
`ifdef FWD_A_EN
        logic       fwd_a;
`endif
    } alu_cmd_t;

    // Bit 5 marks an opcode with no ALU mapping; sel falls back to ADD in that case.
    function automatic logic [5:0] op_to_sel(alu_op_e op);
        case (op)
            OP_MUL:  op_to_sel = {1'b0, SEL_MUL};
            OP_ADD:  op_to_sel = {1'b0, SEL_ADD};
            OP_SUB:  op_to_sel = {1'b0, SEL_SUB};
            OP_AND:  op_to_sel = {1'b0, SEL_AND};
            OP_OR:   op_to_sel = {1'b0, SEL_OR};
            OP_XOR:  op_to_sel = {1'b0, SEL_XOR};
            OP_SMUL: op_to_sel = {1'b0, SEL_SMUL};
            default: op_to_sel = {1'b1, SEL_ADD};
        endcase
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO of alu_cmd_t; FIFO_DEPTH must be a power of 2.
// Entry layout follows alu_cmd_t, so FWD_A_EN widens it automatically.
module alu_cmd_fifo
    import alu_cmd_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic     aclk,
    input  logic     srst,
    input  logic     push,
    input  alu_cmd_t din,
    input  logic     pop,
    output alu_cmd_t dout,
    output logic     full,
    output logic     empty
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0]   DEPTH_CNT = FIFO_DEPTH;
    localparam logic [AW:0]   CNT_ONE   = 1;
    localparam logic [AW-1:0] PTR_ONE   = 1;

    alu_cmd_t      r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wrPtr;
    logic [AW-1:0] r_rdPtr;
    logic [AW:0]   r_count;
    logic          w_doPush;
    logic          w_doPop;

    assign full     = (r_count == DEPTH_CNT);
    assign empty    = (r_count == '0);
    assign w_doPush = push & ~full;
    assign w_doPop  = pop & ~empty;
    assign dout     = r_mem[r_rdPtr];

    // Storage is not reset; the pointers and count alone decide which entries are live.
    always_ff @(posedge aclk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= din;
        end
    end

    always_ff @(posedge aclk) begin
        if (srst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + PTR_ONE;
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + PTR_ONE;
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Command sequencer for BitSliceALU_8bit: buffered ops, fixed settle, in-order responses.
// Define FWD_A_EN to add cmd_fwd_a (previous legal result low byte used as operand a).
module alu_op_sequencer
    import alu_cmd_pkg::*;
#(
    parameter int FIFO_DEPTH    = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic        aclk,
    input  logic        srst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [7:0]  cmd_a,
    input  logic [7:0]  cmd_b,
    input  logic        cmd_cin,
    input  logic        cmd_bin,
`ifdef FWD_A_EN
    input  logic        cmd_fwd_a,
`endif
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic        alu_cin,
    output logic        alu_bin,
    output logic [4:0]  alu_sel,
    input  logic [15:0] alu_z,
    input  logic        alu_carry,
    input  logic        alu_overflow,
    input  logic        alu_negative,
    input  logic        alu_zero,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_z,
    output logic [3:0]  rsp_flags,
    output logic        rsp_err,
    output logic        busy
);

    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_RESP} state_e;

    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = 1;

    state_e        r_state;
    state_e        w_nextState;
    logic [CW-1:0] r_cnt;
    logic [7:0]    r_aluA;
    logic [7:0]    r_aluB;
    logic          r_aluCin;
    logic          r_aluBin;
    logic [4:0]    r_aluSel;
    logic          r_rspValid;
    logic [15:0]   r_rspZ;
    logic [3:0]    r_rspFlags;
    logic          r_rspErr;
    alu_cmd_t      w_cmdIn;
    alu_cmd_t      w_head;
    logic          w_full;
    logic          w_empty;
    logic          w_headIllegal;
    logic [4:0]    w_headSel;
    logic [7:0]    w_opA;
    logic          w_issue;
    logic          w_pop;
    logic          w_loadLegal;
    logic          w_loadIllegal;
    logic          w_capture;
    logic          w_rspTake;

    always_comb begin
        w_cmdIn     = '0;
        w_cmdIn.op  = alu_op_e'(cmd_op);
        w_cmdIn.a   = cmd_a;
        w_cmdIn.b   = cmd_b;
        w_cmdIn.cin = cmd_cin;
        w_cmdIn.bin = cmd_bin;
`ifdef FWD_A_EN
        w_cmdIn.fwd_a = cmd_fwd_a;
`endif
    end

    alu_cmd_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .aclk  (aclk),
        .srst  (srst),
        .push  (cmd_valid & cmd_ready),
        .din   (w_cmdIn),
        .pop   (w_pop),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty)
    );

    assign {w_headIllegal, w_headSel} = op_to_sel(w_head.op);

`ifdef FWD_A_EN
    logic [7:0] r_fwdA;

    // Only captured (legal) results feed the forward register.
    always_ff @(posedge aclk) begin
        if (srst) begin
            r_fwdA <= '0;
        end else if (w_capture) begin
            r_fwdA <= alu_z[7:0];
        end
    end

    assign w_opA = w_head.fwd_a ? r_fwdA : w_head.a;
`else
    assign w_opA = w_head.a;
`endif

    always_ff @(posedge aclk) begin
        if (srst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // A response handshake can issue the next queued command on the same edge.
    always_comb begin
        w_nextState   = r_state;
        w_issue       = 1'b0;
        w_pop         = 1'b0;
        w_loadLegal   = 1'b0;
        w_loadIllegal = 1'b0;
        w_capture     = 1'b0;
        w_rspTake     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_issue = ~w_empty;
            end
            ST_SETTLE: begin
                if (r_cnt == '0) begin
                    w_capture   = 1'b1;
                    w_nextState = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_rspTake   = 1'b1;
                    w_issue     = ~w_empty;
                    w_nextState = ST_IDLE;
                end
            end
            default: w_nextState = ST_IDLE;
        endcase
        if (w_issue) begin
            w_pop = 1'b1;
            if (w_headIllegal) begin
                w_loadIllegal = 1'b1;
                w_nextState   = ST_RESP;
            end else begin
                w_loadLegal = 1'b1;
                w_nextState = ST_SETTLE;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (srst) begin
            r_cnt      <= '0;
            r_aluA     <= '0;
            r_aluB     <= '0;
            r_aluCin   <= 1'b0;
            r_aluBin   <= 1'b1;
            r_aluSel   <= SEL_ADD;
            r_rspValid <= 1'b0;
            r_rspZ     <= '0;
            r_rspFlags <= '0;
            r_rspErr   <= 1'b0;
        end else begin
            if (w_loadLegal) begin
                r_aluA   <= w_opA;
                r_aluB   <= w_head.b;
                r_aluCin <= w_head.cin;
                r_aluBin <= w_head.bin;
                r_aluSel <= w_headSel;
                r_cnt    <= CNT_LOAD;
            end else if (r_state == ST_SETTLE && r_cnt != '0) begin
                r_cnt <= r_cnt - CNT_ONE;
            end

            if (w_loadIllegal) begin
                r_rspZ     <= '0;
                r_rspFlags <= '0;
                r_rspErr   <= 1'b1;
                r_rspValid <= 1'b1;
            end else if (w_capture) begin
                r_rspZ                    <= alu_z;
                r_rspFlags[FLAG_CARRY]    <= alu_carry;
                r_rspFlags[FLAG_OVERFLOW] <= alu_overflow;
                r_rspFlags[FLAG_NEGATIVE] <= alu_negative;
                r_rspFlags[FLAG_ZERO]     <= alu_zero;
                r_rspErr                  <= 1'b0;
                r_rspValid                <= 1'b1;
            end else if (w_rspTake) begin
                r_rspValid <= 1'b0;
            end
        end
    end

    assign cmd_ready = ~w_full & ~srst;
    assign busy      = ~w_empty | (r_state != ST_IDLE);
    assign alu_a     = r_aluA;
    assign alu_b     = r_aluB;
    assign alu_cin   = r_aluCin;
    assign alu_bin   = r_aluBin;
    assign alu_sel   = r_aluSel;
    assign rsp_valid = r_rspValid;
    assign rsp_z     = r_rspZ;
    assign rsp_flags = r_rspFlags;
    assign rsp_err   = r_rspErr;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: behavioural ALU stand-in, in-order scoreboard, directed and random traffic.
// Build with +define+FWD_A_EN to also exercise the forwarded operand path.
`timescale 1ns/1ps
module tb_alu_op_sequencer;

    localparam int FIFO_DEPTH    = 4;
    localparam int SETTLE_CYCLES = 2;

    logic        aclk      = 1'b0;
    logic        srst      = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op    = '0;
    logic [7:0]  cmd_a     = '0;
    logic [7:0]  cmd_b     = '0;
    logic        cmd_cin   = 1'b0;
    logic        cmd_bin   = 1'b0;
`ifdef FWD_A_EN
    logic        cmd_fwd_a = 1'b0;
`endif
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic        alu_cin;
    logic        alu_bin;
    logic [4:0]  alu_sel;
    logic [15:0] alu_z;
    logic        alu_carry;
    logic        alu_overflow;
    logic        alu_negative;
    logic        alu_zero;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [15:0] rsp_z;
    logic [3:0]  rsp_flags;
    logic        rsp_err;
    logic        busy;

    typedef struct packed {
        logic [15:0] z;
        logic [3:0]  flags;
    } alu_res_t;

    typedef struct packed {
        logic [15:0] z;
        logic [3:0]  flags;
        logic        err;
    } exp_t;

    exp_t       sbQ[$];
    int         compCnt  = 0;
    int         failCnt  = 0;
    int         edgeCnt  = 0;
    int         rdyMode  = 0;
    logic [7:0] modelFwd = 8'h00;

    always #5 aclk = ~aclk;
    always @(posedge aclk) edgeCnt <= edgeCnt + 1;

    alu_op_sequencer #(
        .FIFO_DEPTH    (FIFO_DEPTH),
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) dut (
        .aclk         (aclk),
        .srst         (srst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_a        (cmd_a),
        .cmd_b        (cmd_b),
        .cmd_cin      (cmd_cin),
        .cmd_bin      (cmd_bin),
`ifdef FWD_A_EN
        .cmd_fwd_a    (cmd_fwd_a),
`endif
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_cin      (alu_cin),
        .alu_bin      (alu_bin),
        .alu_sel      (alu_sel),
        .alu_z        (alu_z),
        .alu_carry    (alu_carry),
        .alu_overflow (alu_overflow),
        .alu_negative (alu_negative),
        .alu_zero     (alu_zero),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_z        (rsp_z),
        .rsp_flags    (rsp_flags),
        .rsp_err      (rsp_err),
        .busy         (busy)
    );

    // ALU arithmetic by operation index 0..6 (MUL ADD SUB AND OR XOR SMUL); flags {c,o,n,z}.
    function automatic alu_res_t aluCompute(input int opIdx, input logic [7:0] a, input logic [7:0] b,
                                            input logic cin, input logic bin);
        alu_res_t           r;
        logic [8:0]         w9;
        logic signed [15:0] sa;
        logic signed [15:0] sb;
        logic               wide;
        r    = '0;
        w9   = '0;
        wide = 1'b0;
        sa   = {{8{a[7]}}, a};
        sb   = {{8{b[7]}}, b};
        case (opIdx)
            0: begin
                r.z        = {8'h00, a} * {8'h00, b};
                r.flags[2] = |r.z[15:8];
                wide       = 1'b1;
            end
            1: begin
                w9         = {1'b0, a} + {1'b0, b} + {8'h00, cin};
                r.z        = {8'h00, w9[7:0]};
                r.flags[3] = w9[8];
                r.flags[2] = (a[7] == b[7]) && (w9[7] != a[7]);
            end
            2: begin
                w9         = {1'b0, a} - {1'b0, b} - {8'h00, bin};
                r.z        = {8'h00, w9[7:0]};
                r.flags[3] = w9[8];
                r.flags[2] = (a[7] != b[7]) && (w9[7] != a[7]);
            end
            3: r.z = {8'h00, a & b};
            4: r.z = {8'h00, a | b};
            5: r.z = {8'h00, a ^ b};
            6: begin
                r.z  = sa * sb;
                wide = 1'b1;
            end
            default: begin
                r.z = 16'hBAD0;
            end
        endcase
        r.flags[1] = wide ? r.z[15] : r.z[7];
        r.flags[0] = (r.z == 16'h0000);
        if (opIdx < 0 || opIdx > 6) r.flags = 4'b1010;
        return r;
    endfunction

    // ALU stand-in: decodes sel, and shows junk until its inputs have been stable for a full cycle.
    logic [22:0] aluIn;
    logic [22:0] aluInPrev;
    assign aluIn = {alu_a, alu_b, alu_cin, alu_bin, alu_sel};
    always @(posedge aclk) aluInPrev <= aluIn;

    always_comb begin
        int       opIdx;
        alu_res_t r;
        case (alu_sel)
            5'b00000: opIdx = 0;
            5'b00001: opIdx = 1;
            5'b00010: opIdx = 2;
            5'b00100: opIdx = 3;
            5'b01000: opIdx = 4;
            5'b10000: opIdx = 5;
            5'b11111: opIdx = 6;
            default:  opIdx = -1;
        endcase
        r = aluCompute(opIdx, alu_a, alu_b, alu_cin, alu_bin);
        if (aluIn !== aluInPrev) begin
            r.z     = 16'hDEAD;
            r.flags = 4'b1111;
        end
        alu_z        = r.z;
        alu_carry    = r.flags[3];
        alu_overflow = r.flags[2];
        alu_negative = r.flags[1];
        alu_zero     = r.flags[0];
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compCnt++;
        if (act !== exp) begin
            failCnt++;
            $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: each accepted command yields one expected response, computed from its opcode.
    always @(negedge aclk) begin
        exp_t       e;
        alu_res_t   r;
        logic [7:0] aEff;
        if (srst) begin
            sbQ.delete();
            modelFwd = 8'h00;
        end else if (cmd_valid && cmd_ready) begin
            aEff = cmd_a;
`ifdef FWD_A_EN
            if (cmd_fwd_a) aEff = modelFwd;
`endif
            if (cmd_op == 3'd7) begin
                e = '{z: 16'h0000, flags: 4'h0, err: 1'b1};
            end else begin
                r        = aluCompute(int'(cmd_op), aEff, cmd_b, cmd_cin, cmd_bin);
                e        = '{z: r.z, flags: r.flags, err: 1'b0};
                modelFwd = r.z[7:0];
            end
            sbQ.push_back(e);
        end
    end

    // Monitor: pops on each response handshake and checks values are held while stalled.
    logic        stallPrev = 1'b0;
    logic [21:0] holdVal   = '0;
    always @(negedge aclk) begin
        exp_t e;
        if (srst) begin
            stallPrev = 1'b0;
        end else begin
            if (stallPrev) begin
                checkOutput("rsp_hold", {rsp_valid, rsp_err, rsp_flags, rsp_z}, holdVal);
            end
            if (rsp_valid && rsp_ready) begin
                checkOutput("rsp_expected_pending", (sbQ.size() != 0), 1);
                if (sbQ.size() != 0) begin
                    e = sbQ.pop_front();
                    checkOutput("rsp_z", rsp_z, e.z);
                    checkOutput("rsp_flags", rsp_flags, e.flags);
                    checkOutput("rsp_err", rsp_err, e.err);
                end
            end
            stallPrev = rsp_valid && !rsp_ready;
            holdVal   = {rsp_valid, rsp_err, rsp_flags, rsp_z};
        end
    end

    // rsp_ready: 0 = always ready, 1 = stalled, 2 = random.
    initial begin
        forever begin
            @(posedge aclk);
            #1;
            case (rdyMode)
                0:       rsp_ready = 1'b1;
                1:       rsp_ready = 1'b0;
                default: rsp_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic applyStimulus(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                 input logic cin, input logic bin, input logic fwd,
                                 output int acceptEdge);
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_cin   = cin;
        cmd_bin   = bin;
`ifdef FWD_A_EN
        cmd_fwd_a = fwd;
`else
        if (fwd) cmd_cin = cin;
`endif
        cmd_valid  = 1'b1;
        acceptEdge = -1;
        for (int t = 0; t < 300 && acceptEdge < 0; t++) begin
            @(negedge aclk);
            if (cmd_ready) acceptEdge = edgeCnt + 1;
        end
        @(posedge aclk);
        #1;
        cmd_valid = 1'b0;
        checkOutput("cmd_accepted", (acceptEdge >= 0), 1);
    endtask

    task automatic runOne(input string name, input logic [2:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic fwd, input int expLat,
                          input logic [15:0] expZ, input logic expErr,
                          input logic [3:0] flagMask, input logic [3:0] expFlags);
        int   k;
        logic seen;
        applyStimulus(op, a, b, 1'b0, 1'b0, fwd, k);
        seen = 1'b0;
        for (int t = 0; t < 50 && !seen; t++) begin
            @(negedge aclk);
            if (rsp_valid) seen = 1'b1;
        end
        checkOutput({name, "_seen"}, seen, 1);
        if (seen) begin
            checkOutput({name, "_latency"}, edgeCnt - k, expLat);
            checkOutput({name, "_z"}, rsp_z, expZ);
            checkOutput({name, "_err"}, rsp_err, expErr);
            checkOutput({name, "_flags"}, rsp_flags & flagMask, expFlags);
        end
        @(posedge aclk);
        #1;
    endtask

    task automatic waitDrain(input string name);
        logic done;
        done = 1'b0;
        for (int t = 0; t < 1000 && !done; t++) begin
            @(negedge aclk);
            if (sbQ.size() == 0 && !busy && !rsp_valid) done = 1'b1;
        end
        checkOutput(name, done, 1);
        @(posedge aclk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int   k;
        logic anyValid;

        srst = 1'b1;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        checkOutput("rst_cmd_ready", cmd_ready, 0);
        @(posedge aclk);
        #1;
        srst = 1'b0;
        @(posedge aclk);
        @(negedge aclk);
        checkOutput("rst_alu_a", alu_a, 8'h00);
        checkOutput("rst_alu_b", alu_b, 8'h00);
        checkOutput("rst_alu_cin", alu_cin, 0);
        checkOutput("rst_alu_bin", alu_bin, 1);
        checkOutput("rst_alu_sel", alu_sel, 5'b00001);
        checkOutput("rst_rsp", {rsp_valid, rsp_err, rsp_flags, rsp_z}, 22'h0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_cmd_ready_after", cmd_ready, 1);
        @(posedge aclk);
        #1;

        $display("[TB] directed: ADD, MUL, SMUL");
        rdyMode = 0;
        runOne("t1_add",  3'd1, 8'hF0, 8'h0F, 1'b0, SETTLE_CYCLES + 1, 16'h00FF, 1'b0, 4'h0, 4'h0);
        runOne("t2_mul",  3'd0, 8'h40, 8'hFF, 1'b0, SETTLE_CYCLES + 1, 16'h3FC0, 1'b0, 4'h0, 4'h0);
        runOne("t2_smul", 3'd6, 8'hB2, 8'hB2, 1'b0, SETTLE_CYCLES + 1, 16'h17C4, 1'b0, 4'h2, 4'h0);
        runOne("t2_smuln",3'd6, 8'h40, 8'hB2, 1'b0, SETTLE_CYCLES + 1, 16'hEC80, 1'b0, 4'h2, 4'h2);

        $display("[TB] directed: stalled response with full FIFO");
        rdyMode = 1;
        @(posedge aclk);
        #1;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(3'($urandom_range(0, 6)), 8'($urandom), 8'($urandom),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, k);
        end
        @(negedge aclk);
        checkOutput("t3_full_cmd_ready", cmd_ready, 0);
        checkOutput("t3_busy", busy, 1);
        checkOutput("t3_rsp_valid", rsp_valid, 1);
        repeat (3) @(posedge aclk);
        #1;
        rdyMode = 0;
        applyStimulus(3'd5, 8'h5A, 8'h3C, 1'b0, 1'b0, 1'b0, k);
        waitDrain("t3_drain");

        $display("[TB] directed: illegal opcode");
        runOne("t4_ill",  3'd7, 8'h12, 8'h34, 1'b0, 1, 16'h0000, 1'b1, 4'hF, 4'h0);
        runOne("t4_next", 3'd1, 8'h01, 8'h02, 1'b0, SETTLE_CYCLES + 1, 16'h0003, 1'b0, 4'h0, 4'h0);

        $display("[TB] directed: reset during settle");
        applyStimulus(3'd1, 8'h11, 8'h22, 1'b0, 1'b0, 1'b0, k);
        applyStimulus(3'd2, 8'h33, 8'h01, 1'b0, 1'b0, 1'b0, k);
        applyStimulus(3'd3, 8'hF0, 8'h3C, 1'b0, 1'b0, 1'b0, k);
        srst = 1'b1;
        @(posedge aclk);
        #1;
        srst = 1'b0;
        @(negedge aclk);
        checkOutput("t5_rsp_valid", rsp_valid, 0);
        checkOutput("t5_busy", busy, 0);
        anyValid = 1'b0;
        repeat (20) begin
            @(negedge aclk);
            if (rsp_valid) anyValid = 1'b1;
        end
        checkOutput("t5_no_rsp", anyValid, 0);
        @(posedge aclk);
        #1;

`ifdef FWD_A_EN
        $display("[TB] directed: forwarded operand");
        runOne("t6_base", 3'd1, 8'h01, 8'h02, 1'b0, SETTLE_CYCLES + 1, 16'h0003, 1'b0, 4'h0, 4'h0);
        runOne("t6_fwd",  3'd1, 8'hAA, 8'h04, 1'b1, SETTLE_CYCLES + 1, 16'h0007, 1'b0, 4'h0, 4'h0);
`endif

        $display("[TB] random traffic");
        rdyMode = 2;
        for (int i = 0; i < 60; i++) begin
            applyStimulus(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), k);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 6)) @(posedge aclk);
                #1;
            end
        end
        rdyMode = 0;
        waitDrain("rand_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCnt, failCnt);
        $finish;
    end

endmodule
